// File: rtl/t03_sprite_frame_loader.sv
// t03_sprite_frame_loader: fetches one sprite frame word by word into a back buffer
// and copies it to the front buffer at the next vertical blank.
module t03_sprite_frame_loader #(
  parameter int PIX_W      = 8,
  parameter int NPIX       = 300,
  parameter int NUM_FRAMES = 4,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic [3:0]            frame_id,
  input  logic                  vblank,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIX_W-1:0]      mem_rdata,
  input  logic                  mem_rvalid,
  output logic [NPIX*PIX_W-1:0] sprite,
  output logic                  busy,
  output logic                  swapped,
  output logic                  req_err,
  output logic [3:0]            cur_frame
);
  localparam int BW = NPIX * PIX_W;
  localparam int CW = $clog2(NPIX);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, WAIT_VBLANK} state_t;
  state_t r_st, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [ADDR_W-1:0] r_base, w_addr;
  logic [3:0] r_id;
  logic [BW-1:0] r_back;
  logic w_ok, w_acc, w_rej, w_last;
  assign w_ok   = frame_id < 4'(NUM_FRAMES);
  assign w_acc  = r_st == IDLE && load_req && w_ok;
  assign w_rej  = r_st == IDLE && load_req && !w_ok;
  assign w_last = r_cnt == CW'(NPIX - 1);
  // Address of the next strobe: frame base on accept, otherwise the following pixel
  assign w_addr = w_acc ? ADDR_W'(frame_id) * ADDR_W'(NPIX) : r_base + ADDR_W'(r_cnt) + ADDR_W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= IDLE;
    else     r_st <= w_nxt;
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      IDLE:        w_nxt = w_acc ? REQ : IDLE;
      REQ:         w_nxt = WAIT_DATA;
      WAIT_DATA:   w_nxt = mem_rvalid ? (w_last ? WAIT_VBLANK : REQ) : WAIT_DATA;
      WAIT_VBLANK: w_nxt = vblank ? IDLE : WAIT_VBLANK;
      default:     w_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      sprite    <= '0;
      busy      <= 1'b0;
      swapped   <= 1'b0;
      req_err   <= 1'b0;
      cur_frame <= '0;
      r_cnt     <= '0;
      r_base    <= '0;
      r_id      <= '0;
      r_back    <= '0;
    end else begin
      mem_rd_en <= w_nxt == REQ;
      swapped   <= 1'b0;
      req_err   <= w_rej;
      if (w_nxt == REQ) mem_addr <= w_addr;
      if (w_acc) begin
        r_id   <= frame_id;
        r_base <= w_addr;
        r_cnt  <= '0;
        busy   <= 1'b1;
      end
      if (r_st == WAIT_DATA && mem_rvalid) begin
        r_back <= {r_back[BW-PIX_W-1:0], mem_rdata};
        if (!w_last) r_cnt <= r_cnt + CW'(1);
      end
      if (r_st == WAIT_VBLANK && vblank) begin
        sprite    <= r_back;
        cur_frame <= r_id;
        swapped   <= 1'b1;
        busy      <= 1'b0;
      end
    end
  end
endmodule
